// File: rtl/t5_wbctl_pkg.sv
// Shared encodings for the t5 writeback controller: source selects, load funct3 codes,
// hart count and the load-queue entry layout.
package t5_wbctl_pkg;

  localparam int unsigned NHart = 4;

  typedef enum logic [1:0] {
    WbNone = 2'b00,
    WbAlu  = 2'b01,
    WbLink = 2'b10,
    WbLoad = 2'b11
  } wb_sel_e;

  localparam logic [2:0] F3Lb  = 3'b000;
  localparam logic [2:0] F3Lh  = 3'b001;
  localparam logic [2:0] F3Lw  = 3'b010;
  localparam logic [2:0] F3Lbu = 3'b100;
  localparam logic [2:0] F3Lhu = 3'b101;

  typedef struct packed {
    logic [1:0] hart;
    logic [4:0] rd;
    logic [2:0] fn3;
    logic [1:0] off;
  } ldq_entry_t;

endpackage

// File: rtl/t5_ldext.sv
// Load data extraction: pick the byte/half lane from the returned word and sign- or
// zero-extend it according to the load funct3.
module t5_ldext
  import t5_wbctl_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] dti,
  input  logic [2:0]      fn3,
  input  logic [1:0]      off,
  output logic [XLEN-1:0] dout
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = dti[7:0];
    unique case (off)
      2'd0: byte_sel = dti[7:0];
      2'd1: byte_sel = dti[15:8];
      2'd2: byte_sel = dti[23:16];
      2'd3: byte_sel = dti[31:24];
      default: byte_sel = dti[7:0];
    endcase
    half_sel = off[1] ? dti[31:16] : dti[15:0];
  end

  // Unknown funct3 codes fall back to a full-word load.
  always_comb begin
    dout = dti;
    case (fn3)
      F3Lb:    dout = {{(XLEN - 8){byte_sel[7]}}, byte_sel};
      F3Lh:    dout = {{(XLEN - 16){half_sel[15]}}, half_sel};
      F3Lw:    dout = dti;
      F3Lbu:   dout = {{(XLEN - 8){1'b0}}, byte_sel};
      F3Lhu:   dout = {{(XLEN - 16){1'b0}}, half_sel};
      default: dout = dti;
    endcase
  end

endmodule

// File: rtl/t5_wbctl.sv
// Writeback controller for the single GPRF write port: arbitrates load returns, a one-entry
// skid and M-stage ALU/LINK results, and holds harts with pending writes off fetch.
module t5_wbctl
  import t5_wbctl_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned LQD  = 4
) (
  input  logic             sclk,
  input  logic             srst,
  input  logic             mval,
  input  logic [1:0]       mhart,
  input  logic [4:0]       mrd,
  input  logic [1:0]       msel,
  input  logic [2:0]       mfn3,
  input  logic [1:0]       maddr,
  input  logic [XLEN-1:0]  malu,
  input  logic [XLEN-1:0]  mpc,
  input  logic [XLEN-1:0]  dwb_dti,
  input  logic             dwb_ack,
  output logic             mwre,
  output logic [4:0]       rd0a,
  output logic [XLEN-1:0]  rd0d,
  output logic [1:0]       whart,
  output logic [NHart-1:0] hart_busy,
  output logic             wb_stall
);

  localparam int unsigned PtrW = (LQD > 1) ? $clog2(LQD) : 1;
  localparam int unsigned CntW = $clog2(LQD + 1);

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(LQD - 1)) ? '0 : p + 1'b1;
  endfunction

  wb_sel_e sel;
  assign sel = wb_sel_e'(msel);

  ldq_entry_t      ldq_q [LQD];
  ldq_entry_t      head_ent;
  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic            skid_vld_q, skid_vld_d;
  logic [1:0]      skid_hart_q, skid_hart_d;
  logic [4:0]      skid_rd_q, skid_rd_d;
  logic [XLEN-1:0] skid_data_q, skid_data_d;

  logic             mwre_q, mwre_d;
  logic [4:0]       rd0a_q, rd0a_d;
  logic [XLEN-1:0]  rd0d_q, rd0d_d;
  logic [1:0]       whart_q, whart_d;
  logic [NHart-1:0] busy_q, busy_d, busy_set, busy_clr;

  logic            ld_req, a_req, l_win, s_drain, a_win, a_stall, a_skid, ld_stall, push;
  logic [XLEN-1:0] ld_data, a_data;
  logic            win_vld;
  logic [1:0]      win_hart;
  logic [4:0]      win_rd;
  logic [XLEN-1:0] win_data;

  assign head_ent = ldq_q[head_q];
  assign a_data   = (sel == WbLink) ? mpc : malu;

  t5_ldext #(
    .XLEN(XLEN)
  ) u_ldext (
    .dti  (dwb_dti),
    .fn3  (head_ent.fn3),
    .off  (head_ent.off),
    .dout (ld_data)
  );

  // Priority L > S > A; a losing A goes to the skid whenever the skid is free after this edge.
  always_comb begin
    ld_req   = mval & (sel == WbLoad);
    a_req    = mval & ((sel == WbAlu) | (sel == WbLink));
    l_win    = dwb_ack & (cnt_q != '0);
    s_drain  = skid_vld_q & ~l_win;
    a_win    = a_req & ~l_win & ~skid_vld_q;
    a_stall  = a_req & l_win & skid_vld_q;
    a_skid   = a_req & ~a_win & ~a_stall;
    ld_stall = ld_req & (cnt_q == CntW'(LQD));
    wb_stall = a_stall | ld_stall;
    push     = ld_req & ~wb_stall;
  end

  always_comb begin
    win_vld  = 1'b0;
    win_hart = '0;
    win_rd   = '0;
    win_data = '0;
    if (l_win) begin
      win_vld  = 1'b1;
      win_hart = head_ent.hart;
      win_rd   = head_ent.rd;
      win_data = ld_data;
    end else if (skid_vld_q) begin
      win_vld  = 1'b1;
      win_hart = skid_hart_q;
      win_rd   = skid_rd_q;
      win_data = skid_data_q;
    end else if (a_win) begin
      win_vld  = 1'b1;
      win_hart = mhart;
      win_rd   = mrd;
      win_data = a_data;
    end
  end

  always_comb begin
    head_d = l_win ? ptr_inc(head_q) : head_q;
    tail_d = push ? ptr_inc(tail_q) : tail_q;
    cnt_d  = cnt_q;
    case ({push, l_win})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    skid_vld_d  = skid_vld_q & ~s_drain;
    skid_hart_d = skid_hart_q;
    skid_rd_d   = skid_rd_q;
    skid_data_d = skid_data_q;
    if (a_skid) begin
      skid_vld_d  = 1'b1;
      skid_hart_d = mhart;
      skid_rd_d   = mrd;
      skid_data_d = a_data;
    end

    // Set after clear so a new pending write for a hart outlives a completing one.
    busy_set = '0;
    busy_clr = '0;
    if (l_win)   busy_clr[head_ent.hart] = 1'b1;
    if (s_drain) busy_clr[skid_hart_q] = 1'b1;
    if (push)    busy_set[mhart] = 1'b1;
    if (a_skid)  busy_set[mhart] = 1'b1;
    busy_d = (busy_q & ~busy_clr) | busy_set;

    mwre_d  = win_vld & (win_rd != '0);
    rd0a_d  = mwre_d ? win_rd : rd0a_q;
    rd0d_d  = mwre_d ? win_data : rd0d_q;
    whart_d = mwre_d ? win_hart : whart_q;
  end

  always_ff @(posedge sclk) begin
    if (srst) begin
      head_q      <= '0;
      tail_q      <= '0;
      cnt_q       <= '0;
      skid_vld_q  <= 1'b0;
      skid_hart_q <= '0;
      skid_rd_q   <= '0;
      skid_data_q <= '0;
      mwre_q      <= 1'b0;
      rd0a_q      <= '0;
      rd0d_q      <= '0;
      whart_q     <= '0;
      busy_q      <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      cnt_q       <= cnt_d;
      skid_vld_q  <= skid_vld_d;
      skid_hart_q <= skid_hart_d;
      skid_rd_q   <= skid_rd_d;
      skid_data_q <= skid_data_d;
      mwre_q      <= mwre_d;
      rd0a_q      <= rd0a_d;
      rd0d_q      <= rd0d_d;
      whart_q     <= whart_d;
      busy_q      <= busy_d;
    end
  end

  // Queue storage needs no reset: occupancy is tracked by cnt_q alone.
  always_ff @(posedge sclk) begin
    if (push) begin
      ldq_q[tail_q] <= '{hart: mhart, rd: mrd, fn3: mfn3, off: maddr};
    end
  end

  assign mwre      = mwre_q;
  assign rd0a      = rd0a_q;
  assign rd0d      = rd0d_q;
  assign whart     = whart_q;
  assign hart_busy = busy_q;

endmodule

// File: tb/tb_t5_wbctl.sv
// Bench for t5_wbctl: a queue-based model checked every cycle plus directed literal checks.
module tb_t5_wbctl;

  localparam int LQD = 4;

  logic        sclk, srst, mval, dwb_ack;
  logic [1:0]  mhart, msel, maddr;
  logic [4:0]  mrd;
  logic [2:0]  mfn3;
  logic [31:0] malu, mpc, dwb_dti;
  logic        mwre, wb_stall;
  logic [4:0]  rd0a;
  logic [31:0] rd0d;
  logic [1:0]  whart;
  logic [3:0]  hart_busy;

  t5_wbctl #(
    .XLEN(32),
    .LQD (LQD)
  ) dut (
    .sclk      (sclk),
    .srst      (srst),
    .mval      (mval),
    .mhart     (mhart),
    .mrd       (mrd),
    .msel      (msel),
    .mfn3      (mfn3),
    .maddr     (maddr),
    .malu      (malu),
    .mpc       (mpc),
    .dwb_dti   (dwb_dti),
    .dwb_ack   (dwb_ack),
    .mwre      (mwre),
    .rd0a      (rd0a),
    .rd0d      (rd0d),
    .whart     (whart),
    .hart_busy (hart_busy),
    .wb_stall  (wb_stall)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  int n_checks = 0;
  int n_errs   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [1:0] hart;
    logic [4:0] rd;
    logic [2:0] fn3;
    logic [1:0] off;
  } ld_t;
  typedef struct packed {
    logic [1:0]  hart;
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  ld_t         m_ldq[$];
  wr_t         m_skid[$];
  logic        m_mwre;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  logic [1:0]  m_hart;

  function automatic logic [31:0] m_ext(input logic [31:0] d, input logic [2:0] f,
                                        input logic [1:0] o);
    logic [31:0] b, h;
    b = (d >> (8 * o)) & 32'hFF;
    h = (d >> (16 * o[1])) & 32'hFFFF;
    case (f)
      3'b000:  return (b ^ 32'h80) - 32'h80;
      3'b001:  return (h ^ 32'h8000) - 32'h8000;
      3'b100:  return b;
      3'b101:  return h;
      default: return d;
    endcase
  endfunction

  function automatic bit m_a_req();
    return mval && (msel == 2'b01 || msel == 2'b10);
  endfunction

  function automatic bit m_pop();
    return dwb_ack && m_ldq.size() > 0;
  endfunction

  // The M stage stalls when its load cannot enter a full queue, or its ALU/LINK result has
  // neither the write port nor a skid slot free this cycle.
  function automatic bit m_stall();
    bit ld_full, a_blocked;
    ld_full   = mval && msel == 2'b11 && m_ldq.size() == LQD;
    a_blocked = m_a_req() && m_pop() && m_skid.size() != 0;
    return ld_full || a_blocked;
  endfunction

  // A hart is busy while any load or skid write of its own is still pending.
  function automatic logic [3:0] m_busy();
    logic [3:0] b;
    b = '0;
    foreach (m_ldq[i]) b[m_ldq[i].hart] = 1'b1;
    foreach (m_skid[i]) b[m_skid[i].hart] = 1'b1;
    return b;
  endfunction

  bit  s_stall, s_have;
  wr_t s_win, s_a;
  ld_t s_head;

  always @(posedge sclk) begin
    if (srst) begin
      m_ldq.delete();
      m_skid.delete();
      m_mwre = 1'b0;
      m_rd   = '0;
      m_data = '0;
      m_hart = '0;
    end else begin
      s_stall = m_stall();
      s_have  = 1'b0;
      s_win   = '0;
      if (m_pop()) begin
        s_head = m_ldq.pop_front();
        s_win  = '{hart: s_head.hart, rd: s_head.rd, data: m_ext(dwb_dti, s_head.fn3, s_head.off)};
        s_have = 1'b1;
      end else if (m_skid.size() != 0) begin
        s_win  = m_skid.pop_front();
        s_have = 1'b1;
      end
      if (m_a_req() && !s_stall) begin
        s_a = '{hart: mhart, rd: mrd, data: (msel == 2'b01) ? malu : mpc};
        if (!s_have) begin
          s_win  = s_a;
          s_have = 1'b1;
        end else begin
          m_skid.push_back(s_a);
        end
      end
      if (mval && msel == 2'b11 && !s_stall)
        m_ldq.push_back('{hart: mhart, rd: mrd, fn3: mfn3, off: maddr});
      if (s_have && s_win.rd != 0) begin
        m_mwre = 1'b1;
        m_rd   = s_win.rd;
        m_data = s_win.data;
        m_hart = s_win.hart;
      end else begin
        m_mwre = 1'b0;
      end
    end
  end

  always @(negedge sclk) begin
    if (chk_en) begin
      chk("mwre", {31'd0, mwre}, {31'd0, m_mwre});
      chk("rd0a", {27'd0, rd0a}, {27'd0, m_rd});
      chk("rd0d", rd0d, m_data);
      chk("whart", {30'd0, whart}, {30'd0, m_hart});
      chk("hart_busy", {28'd0, hart_busy}, {28'd0, m_busy()});
      chk("wb_stall", {31'd0, wb_stall}, {31'd0, m_stall()});
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic set_m(input logic v, input logic [1:0] h, input logic [4:0] rd,
                       input logic [1:0] s, input logic [2:0] f3, input logic [1:0] off,
                       input logic [31:0] alu, input logic [31:0] pc);
    mval  = v;
    mhart = h;
    mrd   = rd;
    msel  = s;
    mfn3  = f3;
    maddr = off;
    malu  = alu;
    mpc   = pc;
  endtask

  task automatic set_ack(input logic a, input logic [31:0] d);
    dwb_ack = a;
    dwb_dti = d;
  endtask

  task automatic idle();
    set_m(1'b0, 2'd0, 5'd0, 2'b00, 3'd0, 2'd0, 32'd0, 32'd0);
  endtask

  task automatic load_push(input logic [1:0] h, input logic [4:0] rd, input logic [2:0] f3,
                           input logic [1:0] off);
    set_m(1'b1, h, rd, 2'b11, f3, off, 32'd0, 32'd0);
    tick();
    idle();
  endtask

  task automatic ack(input logic [31:0] d);
    set_ack(1'b1, d);
    tick();
    set_ack(1'b0, 32'd0);
  endtask

  initial begin
    srst = 1'b1;
    idle();
    set_ack(1'b0, 32'd0);
    tick();
    tick();
    srst   = 1'b0;
    chk_en = 1'b1;
    chk("rst_mwre", {31'd0, mwre}, 32'd0);
    chk("rst_busy", {28'd0, hart_busy}, 32'd0);
    chk("rst_rd0d", rd0d, 32'd0);

    // ALU write
    set_m(1'b1, 2'd2, 5'd5, 2'b01, 3'd0, 2'd0, 32'hDEADBEEF, 32'd0);
    #1 chk("alu_stall", {31'd0, wb_stall}, 32'd0);
    tick();
    idle();
    chk("alu_mwre", {31'd0, mwre}, 32'd1);
    chk("alu_whart", {30'd0, whart}, 32'd2);
    chk("alu_rd0a", {27'd0, rd0a}, 32'd5);
    chk("alu_rd0d", rd0d, 32'hDEADBEEF);
    tick();

    // LB with busy tracking
    load_push(2'd1, 5'd7, 3'b000, 2'd3);
    chk("lb_busy_set", {28'd0, hart_busy}, 32'h2);
    tick();
    tick();
    chk("lb_busy_hold", {28'd0, hart_busy}, 32'h2);
    ack(32'h80112233);
    chk("lb_mwre", {31'd0, mwre}, 32'd1);
    chk("lb_rd0d", rd0d, 32'hFFFFFF80);
    chk("lb_rd0a", {27'd0, rd0a}, 32'd7);
    chk("lb_busy_clr", {28'd0, hart_busy}, 32'd0);

    // Halfword / byte / fallback extraction
    load_push(2'd0, 5'd9, 3'b101, 2'd2);
    ack(32'hBEEF0000);
    chk("lhu_rd0d", rd0d, 32'h0000BEEF);
    load_push(2'd0, 5'd9, 3'b001, 2'd2);
    ack(32'hBEEF0000);
    chk("lh_rd0d", rd0d, 32'hFFFFBEEF);
    load_push(2'd3, 5'd8, 3'b100, 2'd1);
    ack(32'h0000A500);
    chk("lbu_rd0d", rd0d, 32'h000000A5);
    load_push(2'd2, 5'd6, 3'b011, 2'd1);
    ack(32'hCAFEF00D);
    chk("f3x_rd0d", rd0d, 32'hCAFEF00D);

    // Load and LINK collide with an empty skid
    load_push(2'd0, 5'd3, 3'b010, 2'd0);
    set_m(1'b1, 2'd1, 5'd4, 2'b10, 3'd0, 2'd0, 32'd0, 32'h100);
    set_ack(1'b1, 32'h12345678);
    #1 chk("cf_stall", {31'd0, wb_stall}, 32'd0);
    tick();
    idle();
    set_ack(1'b0, 32'd0);
    chk("cf_l_rd0a", {27'd0, rd0a}, 32'd3);
    chk("cf_l_rd0d", rd0d, 32'h12345678);
    chk("cf_busy", {28'd0, hart_busy}, 32'h2);
    tick();
    chk("cf_a_rd0a", {27'd0, rd0a}, 32'd4);
    chk("cf_a_rd0d", rd0d, 32'h100);
    chk("cf_busy_clr", {28'd0, hart_busy}, 32'd0);

    // Skid full: L, L, A1, A2
    load_push(2'd0, 5'd10, 3'b010, 2'd0);
    load_push(2'd3, 5'd11, 3'b010, 2'd0);
    set_m(1'b1, 2'd1, 5'd12, 2'b01, 3'd0, 2'd0, 32'hA1, 32'd0);
    set_ack(1'b1, 32'h11111111);
    #1 chk("sk_stall0", {31'd0, wb_stall}, 32'd0);
    tick();
    chk("sk_w1", {27'd0, rd0a}, 32'd10);
    set_m(1'b1, 2'd2, 5'd13, 2'b01, 3'd0, 2'd0, 32'hA2, 32'd0);
    set_ack(1'b1, 32'h22222222);
    #1 chk("sk_stall1", {31'd0, wb_stall}, 32'd1);
    tick();
    chk("sk_w2", {27'd0, rd0a}, 32'd11);
    set_ack(1'b0, 32'd0);
    #1 chk("sk_stall2", {31'd0, wb_stall}, 32'd0);
    tick();
    idle();
    chk("sk_w3", rd0d, 32'hA1);
    tick();
    chk("sk_w4", rd0d, 32'hA2);

    // Full queue refuses a fifth load; four back-to-back returns with the skid held full
    load_push(2'd0, 5'd16, 3'b010, 2'd0);
    load_push(2'd1, 5'd17, 3'b010, 2'd0);
    load_push(2'd2, 5'd18, 3'b010, 2'd0);
    load_push(2'd3, 5'd19, 3'b010, 2'd0);
    set_m(1'b1, 2'd0, 5'd25, 2'b11, 3'b010, 2'd0, 32'd0, 32'd0);
    #1 chk("qf_stall", {31'd0, wb_stall}, 32'd1);
    tick();
    set_m(1'b1, 2'd0, 5'd20, 2'b01, 3'd0, 2'd0, 32'h20, 32'd0);
    set_ack(1'b1, 32'h16);
    tick();
    set_m(1'b1, 2'd1, 5'd21, 2'b01, 3'd0, 2'd0, 32'h21, 32'd0);
    set_ack(1'b1, 32'h17);
    #1 chk("b2b_stall", {31'd0, wb_stall}, 32'd1);
    tick();
    set_ack(1'b1, 32'h18);
    tick();
    set_ack(1'b1, 32'h19);
    tick();
    chk("b2b_l4", {27'd0, rd0a}, 32'd19);
    set_ack(1'b0, 32'd0);
    tick();
    idle();
    chk("b2b_s", {27'd0, rd0a}, 32'd20);
    tick();
    chk("b2b_a", {27'd0, rd0a}, 32'd21);
    ack(32'hFFFF);
    chk("empty_ack", {31'd0, mwre}, 32'd0);

    // Push and pop in the same cycle
    load_push(2'd0, 5'd14, 3'b010, 2'd0);
    set_m(1'b1, 2'd1, 5'd15, 2'b11, 3'b100, 2'd0, 32'd0, 32'd0);
    set_ack(1'b1, 32'h55);
    tick();
    idle();
    set_ack(1'b0, 32'd0);
    chk("pp_rd0a", {27'd0, rd0a}, 32'd14);
    chk("pp_busy", {28'd0, hart_busy}, 32'h2);
    ack(32'hC3);
    chk("pp_rd0d", rd0d, 32'hC3);

    // rd0 load pops and clears busy without writing
    load_push(2'd2, 5'd0, 3'b010, 2'd0);
    chk("rd0_busy", {28'd0, hart_busy}, 32'h4);
    ack(32'h99);
    chk("rd0_mwre", {31'd0, mwre}, 32'd0);
    chk("rd0_busy_clr", {28'd0, hart_busy}, 32'd0);

    // Reset with three loads outstanding
    load_push(2'd0, 5'd1, 3'b010, 2'd0);
    load_push(2'd1, 5'd2, 3'b010, 2'd0);
    load_push(2'd2, 5'd3, 3'b010, 2'd0);
    chk("pre_rst_busy", {28'd0, hart_busy}, 32'h7);
    srst = 1'b1;
    tick();
    srst = 1'b0;
    chk("post_rst_busy", {28'd0, hart_busy}, 32'd0);
    ack(32'h77);
    chk("post_rst_ack", {31'd0, mwre}, 32'd0);
    tick();
    tick();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/t5_wbctl.md
Name: t5_wbctl

Overview:
- Writeback controller for the single GPRF write port (rd0a/rd0d/mwre) of the 4-hart barrel core.
- Arbitrates per cycle between three sources: ALU results, link PCs from the M stage, and late-returning load data from the data wishbone.
- Tracks outstanding loads per hart and holds those harts off fetch until their data is written.
- Sits between the M stage / dwb interface and t5_regs.

Parameters:
- XLEN, 32, datapath width.
- LQD, 4, load queue depth; must equal the hart count.

Ports:
- sclk  in  1  system clock.
- srst  in  1  reset; synchronous, active-high.
- mval  in  1  M stage holds a valid instruction this cycle.
- mhart  in  2  hart of the M-stage instruction.
- mrd  in  5  destination register.
- msel  in  2  writeback source: 00 none, 01 ALU, 10 LINK, 11 LOAD.
- mfn3  in  3  load funct3 (size/sign).
- maddr  in  2  load byte offset.
- malu  in  XLEN  ALU result.
- mpc  in  XLEN  link value (pc+4).
- dwb_dti  in  XLEN  load data from dwb.
- dwb_ack  in  1  load data valid; returns in request order.
- mwre  out  1  GPRF write enable.
- rd0a  out  5  GPRF write address.
- rd0d  out  XLEN  GPRF write data.
- whart  out  2  GPRF write hart.
- hart_busy  out  4  per-hart hold to fetch; a busy hart must not issue.
- wb_stall  out  1  M stage must hold its instruction this cycle.

Behaviour:
- Reset (srst=1 at a sclk edge): mwre, rd0a, rd0d, whart, hart_busy = 0; load queue and skid are emptied. Pending state is discarded.
- Load push: mval & msel=11 & ~wb_stall pushes {mhart, mrd, mfn3, maddr} onto the in-order queue and sets hart_busy[mhart] at the next edge. If the queue is full, assert wb_stall and do not push. This cannot happen with legal issue, but the bench must still check it.
- Load pop: dwb_ack with a non-empty queue pops the head. Data extraction:
  - Select the byte lane by offset. LB/LBU use byte maddr. LH/LHU use half maddr[1].
  - funct3 000 LB sign-extend, 001 LH sign-extend, 010 LW, 100 LBU zero-extend, 101 LHU zero-extend; any other code is treated as LW.
- dwb_ack with an empty queue: ignored, no write, no state change.
- Candidates each cycle:
  - L = load pop.
  - S = skid register (one entry).
  - A = M-stage ALU/LINK, i.e. mval & msel in {01,10}; data is malu or mpc.
  - Fixed priority L > S > A.
- Losing candidates:
  - If A loses and the skid is empty (or is draining this cycle), A is captured into the skid and hart_busy[hart] is set.
  - If A loses and the skid stays occupied, wb_stall=1 (combinational, same cycle) and A is not consumed.
  - S only loses to L and then stays put.
- Write port outputs are registered, with latency 1 cycle from the winning event.
  - mwre=1 for the cycle after a winner with rd≠0.
  - rd=0 winner: mwre=0, but the pop and skid-drain and the busy clear still happen.
  - rd0a, rd0d and whart hold their last values when mwre=0.
- hart_busy[h] clears on the same edge that registers the write for h's load or skid entry. If a set and a clear for the same hart coincide, set wins; this is only legal for different-source events.
- Push and pop in the same cycle: both happen and the queue count is unchanged.
- Simultaneous L and A with an empty skid: L writes at T+1, A at T+2 from the skid, and wb_stall stays 0.
- Back-to-back L for 4 cycles with a full skid: A stalls throughout, then drains in order S, A.
- Reset mid-operation: a dwb_ack arriving after reset finds an empty queue and is dropped.

Decomposition:
- Shared include t5_defs.vh holds:
  - WB_NONE/WB_ALU/WB_LINK/WB_LOAD encodings;
  - funct3 load codes (LB, LH, LW, LBU, LHU);
  - NHART=4.
- Sub-module t5_ldext: combinational lane select plus sign/zero extend; inputs dti, fn3, off; output XLEN.
- The queue is a small circular buffer with head/tail/count kept inside t5_wbctl.

Test Plan:
- ALU write: mval=1 msel=01 mhart=2 mrd=5 malu=0xDEADBEEF -> next cycle mwre=1, whart=2, rd0a=5, rd0d=0xDEADBEEF, wb_stall=0.
- Load LB: push hart1 rd7 fn3=000 maddr=3; 3 cycles later dwb_ack with dti=0x80112233 -> rd0d=0xFFFFFF80. hart_busy[1] is 1 from push+1 until the write edge, then 0.
- LHU: maddr=2, dti=0xBEEF0000 -> rd0d=0x0000BEEF. LH with the same input -> 0xFFFFBEEF.
- Conflict: dwb_ack (hart0 rd3) and A (hart1 rd4 LINK mpc=0x100) in the same cycle -> load written at T+1, rd4=0x100 at T+2, hart_busy[1] high for T+1 only, no stall.
- Skid full: acks on 2 consecutive cycles while A is valid both cycles -> second A sees wb_stall=1 and is held. The final write order is L, L, A1, A2.
- Edge cases:
  - rd0 load: pops and clears busy, but mwre=0.
  - dwb_ack on an empty queue: no write.
  - srst asserted with 3 loads queued: hart_busy=0 next cycle, and subsequent acks are ignored.
